// File: rtl/shot_controller.sv
// Shot sequencer for the billiard game: aims the cue, charges power while shoot is held,
// fires a one-cycle launch strobe and follows the balls until they stop again.
module shot_controller #(
  parameter int         ANGLE_BITS          = 5,
  parameter logic [7:0] POWER_MAX           = 8'd63,
  parameter logic [7:0] POWER_STEP          = 8'd1,
  parameter int         AIM_REPEAT_FRAMES   = 4,
  parameter int         MOVE_TIMEOUT_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  ballsStopped,
  input  logic                  gameFinished,
  input  logic                  keyLeft,
  input  logic                  keyRight,
  input  logic                  keyShoot,
  output logic [ANGLE_BITS-1:0] cueAngle,
  output logic [7:0]            shotPower,
  output logic                  lineWriteEnable,
  output logic                  aimActive,
  output logic                  charging
);

  localparam int REP_W = $clog2(AIM_REPEAT_FRAMES + 1);
  localparam int TO_W  = $clog2(MOVE_TIMEOUT_FRAMES + 1);

  localparam logic [REP_W-1:0] REP_LOAD = REP_W'(AIM_REPEAT_FRAMES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(MOVE_TIMEOUT_FRAMES);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] AIM       = 3'd1;
  localparam logic [2:0] CHARGE    = 3'd2;
  localparam logic [2:0] FIRE      = 3'd3;
  localparam logic [2:0] WAIT_MOVE = 3'd4;
  localparam logic [2:0] WAIT_STOP = 3'd5;

  logic [2:0]            state_q,   state_d;
  logic [ANGLE_BITS-1:0] angle_q,   angle_d;
  logic [7:0]            power_q,   power_d;
  logic [REP_W-1:0]      repeat_q,  repeat_d;
  logic [TO_W-1:0]       timeout_q, timeout_d;
  logic                  armed_q,   armed_d;

  logic [8:0]            powerSum;
  logic [TO_W-1:0]       timeoutNext;
  logic                  oneKey;

  assign powerSum    = {1'b0, power_q} + {1'b0, POWER_STEP};
  assign timeoutNext = timeout_q + TO_W'(1);
  assign oneKey      = keyLeft ^ keyRight;

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    power_d   = power_q;
    repeat_d  = repeat_q;
    timeout_d = timeout_q;
    armed_d   = armed_q;

    case (state_q)
      IDLE: begin
        armed_d = 1'b0;
        if (ballsStopped && !gameFinished) state_d = AIM;
      end

      // A shoot key still held from the previous shot must be released before it can charge.
      AIM: begin
        if (!keyShoot) armed_d = 1'b1;
        if (gameFinished || !ballsStopped) begin
          state_d = IDLE;
          armed_d = 1'b0;
        end else if (keyShoot && armed_q) begin
          state_d = CHARGE;
          power_d = 8'd0;
        end else if (startOfFrame) begin
          if (oneKey) begin
            if (repeat_q == '0) begin
              angle_d  = keyRight ? angle_q + ANGLE_BITS'(1) : angle_q - ANGLE_BITS'(1);
              repeat_d = REP_LOAD;
            end else begin
              repeat_d = repeat_q - REP_W'(1);
            end
          end else begin
            repeat_d = '0;
          end
        end
      end

      CHARGE: begin
        if (gameFinished || !ballsStopped) begin
          state_d = IDLE;
          power_d = 8'd0;
          armed_d = 1'b0;
        end else if (!keyShoot) begin
          state_d = (power_q == 8'd0) ? AIM : FIRE;
        end else if (startOfFrame) begin
          power_d = (powerSum > {1'b0, POWER_MAX}) ? POWER_MAX : powerSum[7:0];
        end
      end

      FIRE: begin
        state_d   = WAIT_MOVE;
        timeout_d = '0;
      end

      // Balls that never start moving still return control after the timeout.
      WAIT_MOVE: begin
        if (!ballsStopped) begin
          state_d = WAIT_STOP;
        end else if (startOfFrame) begin
          if (timeoutNext == TO_LAST) begin
            state_d   = IDLE;
            power_d   = 8'd0;
            timeout_d = '0;
            armed_d   = 1'b0;
          end else begin
            timeout_d = timeoutNext;
          end
        end
      end

      WAIT_STOP: begin
        if (ballsStopped) begin
          state_d = IDLE;
          power_d = 8'd0;
          armed_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      angle_q   <= '0;
      power_q   <= 8'd0;
      repeat_q  <= '0;
      timeout_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      power_q   <= power_d;
      repeat_q  <= repeat_d;
      timeout_q <= timeout_d;
      armed_q   <= armed_d;
    end
  end

  assign cueAngle        = angle_q;
  assign shotPower       = power_q;
  assign lineWriteEnable = (state_q == FIRE);
  assign aimActive       = (state_q == AIM) || (state_q == CHARGE);
  assign charging        = (state_q == CHARGE);

endmodule

// File: tb/tb_shot_controller.sv
// Directed vector bench for shot_controller: a table of per-step inputs with hand-computed
// outputs, followed by a hand-written FIRE/WAIT_STOP/reset sequence.
module tb_shot_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, ballsStopped, gameFinished;
  logic       keyLeft, keyRight, keyShoot;
  logic [4:0] cueAngle;
  logic [7:0] shotPower;
  logic       lineWriteEnable, aimActive, charging;

  int vectorCount = 0;
  int missCount   = 0;
  int strobeCount = 0;

  typedef struct {
    logic       bs, gf, kl, kr, ks;
    int         frames, idles;
    logic [4:0] angle;
    logic [7:0] power;
    logic       lwe, aim, chg;
    int         strobes;
  } vec_t;

  vec_t vecs [0:37];

  shot_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .ballsStopped(ballsStopped), .gameFinished(gameFinished),
    .keyLeft(keyLeft), .keyRight(keyRight), .keyShoot(keyShoot),
    .cueAngle(cueAngle), .shotPower(shotPower), .lineWriteEnable(lineWriteEnable),
    .aimActive(aimActive), .charging(charging)
  );

  always #5 clk = ~clk;

  // Counts every cycle spent in FIRE, so a missing or extra strobe shows up later.
  always @(negedge clk) if (lineWriteEnable) strobeCount++;

  function automatic vec_t mk(int bs, int gf, int kl, int kr, int ks, int fr, int id,
                              int ang, int pw, int l, int a, int c, int st);
    vec_t v;
    v.bs = (bs != 0); v.gf = (gf != 0); v.kl = (kl != 0); v.kr = (kr != 0); v.ks = (ks != 0);
    v.frames = fr; v.idles = id;
    v.angle = 5'(ang); v.power = 8'(pw);
    v.lwe = (l != 0); v.aim = (a != 0); v.chg = (c != 0);
    v.strobes = st;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    ballsStopped = v.bs; gameFinished = v.gf;
    keyLeft = v.kl; keyRight = v.kr; keyShoot = v.ks;
    for (int f = 0; f < v.frames; f++) begin
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0; tick();
    end
    for (int c = 0; c < v.idles; c++) tick();
  endtask

  task automatic checkOutput(input int id, input logic [4:0] ang, input logic [7:0] pw,
                             input logic l, input logic a, input logic c, input int st);
    vectorCount++;
    if (cueAngle !== ang || shotPower !== pw || lineWriteEnable !== l ||
        aimActive !== a || charging !== c || strobeCount != st) begin
      missCount++;
      $display("[TB] FAIL step%0d: got angle=%0d power=%0d lwe=%b aim=%b chg=%b strobes=%0d, expected angle=%0d power=%0d lwe=%b aim=%b chg=%b strobes=%0d",
               id, cueAngle, shotPower, lineWriteEnable, aimActive, charging, strobeCount,
               ang, pw, l, a, c, st);
    end
  endtask

  initial begin
    //              bs gf kl kr ks  fr  id  ang  pw  l a c st
    vecs[0]  = mk(1, 0, 0, 0, 0,   0,  1,   0,  0, 0,1,0, 0);
    vecs[1]  = mk(1, 0, 0, 1, 0,   9,  0,   3,  0, 0,1,0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0,   1,  0,   3,  0, 0,1,0, 0);
    vecs[3]  = mk(1, 0, 1, 0, 0,   1,  0,   2,  0, 0,1,0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0,   1,  0,   2,  0, 0,1,0, 0);
    vecs[5]  = mk(1, 0, 1, 0, 0,   1,  0,   1,  0, 0,1,0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0,   1,  0,   1,  0, 0,1,0, 0);
    vecs[7]  = mk(1, 0, 1, 0, 0,   1,  0,   0,  0, 0,1,0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0,   1,  0,   0,  0, 0,1,0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 0,   1,  0,  31,  0, 0,1,0, 0);
    vecs[10] = mk(1, 0, 1, 0, 0,   4,  0,  30,  0, 0,1,0, 0);
    vecs[11] = mk(1, 0, 1, 1, 0,   1,  0,  30,  0, 0,1,0, 0);
    vecs[12] = mk(1, 0, 0, 0, 0,   0,  1,  30,  0, 0,1,0, 0);
    vecs[13] = mk(1, 0, 0, 0, 1,   0,  1,  30,  0, 0,1,1, 0);
    vecs[14] = mk(1, 0, 0, 0, 1,  10,  0,  30, 10, 0,1,1, 0);
    vecs[15] = mk(1, 0, 0, 0, 0,   0,  1,  30, 10, 1,0,0, 0);
    vecs[16] = mk(1, 0, 0, 0, 0,   0,  1,  30, 10, 0,0,0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0,  20,  0,  30, 10, 0,0,0, 1);
    vecs[18] = mk(1, 0, 0, 0, 0,   0,  1,  30,  0, 0,0,0, 1);
    vecs[19] = mk(1, 0, 0, 0, 0,   0,  1,  30,  0, 0,1,0, 1);
    vecs[20] = mk(1, 0, 0, 0, 0,   0,  1,  30,  0, 0,1,0, 1);
    vecs[21] = mk(1, 0, 0, 0, 1,   0,  1,  30,  0, 0,1,1, 1);
    vecs[22] = mk(1, 0, 0, 0, 1, 100,  0,  30, 63, 0,1,1, 1);
    vecs[23] = mk(1, 0, 0, 0, 0,   0,  1,  30, 63, 1,0,0, 1);
    vecs[24] = mk(1, 0, 0, 0, 0,   0,  1,  30, 63, 0,0,0, 2);
    vecs[25] = mk(1, 0, 0, 0, 0,   7,  0,  30, 63, 0,0,0, 2);
    vecs[26] = mk(1, 0, 0, 0, 0,   1,  0,  30,  0, 0,1,0, 2);
    vecs[27] = mk(0, 0, 0, 0, 1,   0,  1,  30,  0, 0,0,0, 2);
    vecs[28] = mk(1, 0, 0, 0, 1,   0,  1,  30,  0, 0,1,0, 2);
    vecs[29] = mk(1, 0, 0, 0, 1,   3,  0,  30,  0, 0,1,0, 2);
    vecs[30] = mk(1, 0, 0, 0, 0,   0,  1,  30,  0, 0,1,0, 2);
    vecs[31] = mk(1, 0, 0, 0, 1,   0,  1,  30,  0, 0,1,1, 2);
    vecs[32] = mk(1, 0, 0, 0, 0,   0,  1,  30,  0, 0,1,0, 2);
    vecs[33] = mk(1, 0, 0, 0, 1,   0,  1,  30,  0, 0,1,1, 2);
    vecs[34] = mk(1, 0, 0, 1, 1,   5,  0,  30,  5, 0,1,1, 2);
    vecs[35] = mk(1, 1, 0, 0, 1,   0,  1,  30,  0, 0,0,0, 2);
    vecs[36] = mk(1, 1, 0, 0, 0,   0,  2,  30,  0, 0,0,0, 2);
    vecs[37] = mk(1, 0, 0, 0, 0,   0,  1,  30,  0, 0,1,0, 2);

    resetN = 1'b0; startOfFrame = 1'b0; ballsStopped = 1'b0; gameFinished = 1'b0;
    keyLeft = 1'b0; keyRight = 1'b0; keyShoot = 1'b0;
    tick(); tick();
    checkOutput(100, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 0);
    resetN = 1'b1;
    tick();

    for (int i = 0; i < 38; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i].angle, vecs[i].power, vecs[i].lwe, vecs[i].aim, vecs[i].chg,
                  vecs[i].strobes);
    end

    // FIRE ignores gameFinished, then an asynchronous reset lands in the middle of WAIT_STOP.
    ballsStopped = 1'b1; gameFinished = 1'b0; keyShoot = 1'b0; tick();
    keyShoot = 1'b1; tick();
    for (int f = 0; f < 2; f++) begin
      startOfFrame = 1'b1; tick();
      startOfFrame = 1'b0; tick();
    end
    checkOutput(101, 5'd30, 8'd2, 1'b0, 1'b1, 1'b1, 2);
    keyShoot = 1'b0; tick();
    checkOutput(102, 5'd30, 8'd2, 1'b1, 1'b0, 1'b0, 2);
    gameFinished = 1'b1; tick();
    checkOutput(103, 5'd30, 8'd2, 1'b0, 1'b0, 1'b0, 3);
    ballsStopped = 1'b0; tick(); tick();
    checkOutput(104, 5'd30, 8'd2, 1'b0, 1'b0, 1'b0, 3);
    #2 resetN = 1'b0;
    #1 checkOutput(105, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3);
    tick();
    resetN = 1'b1; ballsStopped = 1'b1; gameFinished = 1'b0;
    tick();
    checkOutput(106, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
